store_data_rmw: RTL and testbench
=================================

// Module: store_data_rmw
// PURPOSE
//  Store-side counterpart of the load extractor: performs sb/sh/sw to a word-wide data
//  memory with no byte enables, via read-modify-write (RMW). Sits between the
//  MEM-stage store request and the data RAM port. Captures one request, reads the
//  target word, merges the byte/halfword lane, writes the word back, then signals Done.
// PARAMETERS
//  ADDR_WIDTH      32  byte-address width
//  TIMEOUT_CYCLES  16  max cycles waiting on Mem_Read_Valid before abort (>=2)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  Req_Valid       in   1   store request valid
//  Req_Ready       out  1   unit idle, request accepted when Req_Valid&&Req_Ready
//  Memory_Byte     in   2   2'b11 byte, 2'b10 halfword, 2'b00/2'b01 word
//  Address         in   ADDR_WIDTH  byte address of store
//  Data_In         in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  Mem_Addr        out  ADDR_WIDTH  word address, bits[1:0] forced 0
//  Mem_Read_En     out  1   one-cycle read strobe
//  Mem_Read_Data   in   32  word returned by memory
//  Mem_Read_Valid  in   1   Mem_Read_Data valid this cycle
//  Mem_Write_En    out  1   write request, held until Mem_Write_Ready
//  Mem_Write_Data  out  32  merged word
//  Mem_Write_Ready in   1   memory accepts write this cycle
//  Done            out  1   one-cycle pulse: store committed
//  Error           out  1   one-cycle pulse: misaligned or read timeout, no write
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 incl. Req_Ready; Req_Ready rises 1 cycle after rst_n high.
//  Reset mid-operation: immediate abort, no write issued, captured request discarded.
//  States: IDLE -> READ -> WAIT -> WRITE -> DONE -> IDLE; IDLE -> ERR -> IDLE; WAIT -> ERR.
//  IDLE: Req_Ready=1. On accept, register Memory_Byte/Address/Data_In; Req_Ready=0 next cycle.
//   Misaligned (half with Address[0]=1, word with Address[1:0]!=0) -> ERR, no mem access.
//  READ: Mem_Read_En=1 for exactly one cycle, Mem_Addr={Address[ADDR_WIDTH-1:2],2'b00}.
//  WAIT: timeout counter counts cycles; Mem_Read_Valid -> merge, go WRITE. Counter reaching
//   TIMEOUT_CYCLES without valid -> ERR. Mem_Read_Valid outside WAIT is ignored.
//  Merge: byte -> lane Address[1:0] (00:[7:0] 01:[15:8] 10:[23:16] 11:[31:24]) = Data_In[7:0];
//   half -> Address[1]=0:[15:0], 1:[31:16] = Data_In[15:0]; word -> Data_In. Other lanes kept.
//  WRITE: Mem_Write_En=1, Mem_Addr and Mem_Write_Data stable until Mem_Write_Ready sampled 1.
//  DONE: Done=1 one cycle, then IDLE (Req_Ready=1 following cycle).
//  ERR: Error=1 one cycle, then IDLE. Done and Error never both 1.
//  Mem_Read_Valid and Mem_Write_Ready may be asserted the first cycle of WAIT/WRITE.
//  Minimum latency accept->Done pulse: 4 cycles (read and write ready immediately).
// CONFIGURATION
//  STORE_WORD_FASTPATH_EN defined: aligned word stores skip READ/WAIT, IDLE -> WRITE with
//   Mem_Write_Data=Data_In; min latency 2 cycles. Undefined: all stores use full RMW path.
// TESTING
//  sb Address=0x103 Data_In=0xAB, memory 0x11223344 -> write 0xAB223344 @0x100, Done once.
//  sh Address=0x202 Data_In=0xBEEF, memory 0x11223344 -> write 0xBEEF3344 @0x200.
//  sh Address=0x201 -> Error pulse, Mem_Read_En and Mem_Write_En never asserted.
//  sw 0x300 Data_In=0xDEADBEEF, Mem_Write_Ready delayed 3 cycles -> En/Data stable 4 cycles;
//   fastpath macro on: no Mem_Read_En; off: one read strobe before write.
//  sb with Mem_Read_Valid never asserted -> Error after TIMEOUT_CYCLES=16, no write.
//  rst_n low during WRITE -> Mem_Write_En low immediately, Req_Ready=1 1 cycle after release.

Source files
------------

// File: rtl/store_data_rmw.sv
// Store unit for a word-wide data RAM without byte enables: sb/sh/sw are done as
// read-modify-write. Optional macro STORE_WORD_FASTPATH_EN lets aligned sw skip the read.
module store_data_rmw #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic [1:0]            Memory_Byte,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           Data_In,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic                  Mem_Read_En,
  input  logic [31:0]           Mem_Read_Data,
  input  logic                  Mem_Read_Valid,
  output logic                  Mem_Write_En,
  output logic [31:0]           Mem_Write_Data,
  input  logic                  Mem_Write_Ready,
  output logic                  Done,
  output logic                  Error,
  output logic [2:0]            dbg_state
);

  // Handshakes: a request transfers on a cycle where Req_Valid && Req_Ready; a read
  // returns on a WAIT cycle with Mem_Read_Valid; a write commits on a WRITE cycle with
  // Mem_Write_Ready, and Mem_Write_En/Mem_Addr/Mem_Write_Data hold until then.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

`ifdef STORE_WORD_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  localparam int TCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);

  state_t                state, state_d;
  logic                  armed;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [31:0]           wdata_q, wdata_d;
  logic [TCW-1:0]        tcnt, tcnt_d;
  logic                  accept;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    is_misaligned = 1'b0;
    case (size)
      2'b11:   is_misaligned = 1'b0;
      2'b10:   is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [1:0] size, input logic [1:0] lane,
                                        input logic [31:0] old, input logic [31:0] din);
    merge = old;
    case (size)
      2'b11: begin
        case (lane)
          2'b00:   merge[7:0]   = din[7:0];
          2'b01:   merge[15:8]  = din[7:0];
          2'b10:   merge[23:16] = din[7:0];
          default: merge[31:24] = din[7:0];
        endcase
      end
      2'b10: begin
        if (lane[1]) merge[31:16] = din[15:0];
        else         merge[15:0]  = din[15:0];
      end
      default: merge = din;
    endcase
  endfunction

  // Ready is held low for the first cycle out of reset.
  assign Req_Ready = armed && (state == S_IDLE);
  assign accept    = Req_Valid && Req_Ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      tcnt    <= '0;
    end else begin
      state   <= state_d;
      armed   <= 1'b1;
      wdata_q <= wdata_d;
      tcnt    <= tcnt_d;
      if (accept) begin
        size_q <= Memory_Byte;
        addr_q <= Address;
        data_q <= Data_In;
      end
    end
  end

  always_comb begin
    state_d = state;
    wdata_d = wdata_q;
    tcnt_d  = tcnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_misaligned(Memory_Byte, Address[1:0])) begin
            state_d = S_ERR;
          end else if (FASTPATH && !Memory_Byte[1]) begin
            state_d = S_WRITE;
            wdata_d = Data_In;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
        tcnt_d  = '0;
      end
      S_WAIT: begin
        if (Mem_Read_Valid) begin
          wdata_d = merge(size_q, addr_q[1:0], Mem_Read_Data, data_q);
          state_d = S_WRITE;
        end else if (tcnt == TC_LAST) begin
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      S_WRITE: begin
        if (Mem_Write_Ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state only, so an async reset drops them at once.
  always_comb begin
    Mem_Addr       = '0;
    Mem_Read_En    = 1'b0;
    Mem_Write_En   = 1'b0;
    Mem_Write_Data = '0;
    Done           = 1'b0;
    Error          = 1'b0;
    case (state)
      S_READ: begin
        Mem_Read_En = 1'b1;
        Mem_Addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      end
      S_WAIT: Mem_Addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      S_WRITE: begin
        Mem_Write_En   = 1'b1;
        Mem_Addr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        Mem_Write_Data = wdata_q;
      end
      S_DONE:  Done  = 1'b1;
      S_ERR:   Error = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_store_data_rmw.sv
// Self-checking bench for store_data_rmw: memory responder, scoreboard monitor and a
// word-array reference model of sb/sh/sw semantics.
module tb_store_data_rmw;
  localparam int AW = 32;
  localparam int W  = 67;
  localparam logic [1:0] K_DONE = 2'b10;
  localparam logic [1:0] K_ERR  = 2'b01;
`ifdef STORE_WORD_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Req_Valid = 1'b0;
  logic          Req_Ready;
  logic [1:0]    Memory_Byte = 2'b00;
  logic [AW-1:0] Address = '0;
  logic [31:0]   Data_In = '0;
  logic [AW-1:0] Mem_Addr;
  logic          Mem_Read_En;
  logic [31:0]   Mem_Read_Data;
  logic          Mem_Read_Valid;
  logic          Mem_Write_En;
  logic [31:0]   Mem_Write_Data;
  logic          Mem_Write_Ready;
  logic          Done;
  logic          Error;
  logic [2:0]    dbg_state;

  store_data_rmw #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Memory_Byte(Memory_Byte), .Address(Address), .Data_In(Data_In),
    .Mem_Addr(Mem_Addr), .Mem_Read_En(Mem_Read_En),
    .Mem_Read_Data(Mem_Read_Data), .Mem_Read_Valid(Mem_Read_Valid),
    .Mem_Write_En(Mem_Write_En), .Mem_Write_Data(Mem_Write_Data),
    .Mem_Write_Ready(Mem_Write_Ready),
    .Done(Done), .Error(Error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] ram[256];
  logic [31:0] ref_mem[256];
  int  rd_delay = 0;
  int  wr_delay = 0;
  bit  no_read_resp = 1'b0;
  int  resp_cnt = 0;
  time resp_time = 0;
  time t_issue = 0;
  int  issue_base = 0;
  int  last_wr_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no_event required=event_within_bound", name);
  endtask

  // Reference semantics: replace the addressed byte/half lane, or the whole word.
  function automatic logic [31:0] model_merge(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] old);
    int sh;
    if (sz == 2'b11) begin
      sh = 8 * int'(a[1:0]);
      return (old & ~(32'h0000_00FF << sh)) | ((d & 32'h0000_00FF) << sh);
    end else if (sz == 2'b10) begin
      sh = 16 * int'(a[1]);
      return (old & ~(32'h0000_FFFF << sh)) | ((d & 32'h0000_FFFF) << sh);
    end
    return d;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b10 && a[0]) || (sz[1] == 1'b0 && a[1:0] != 2'b00);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    ram[a[9:2]]     = v;
    ref_mem[a[9:2]] = v;
  endtask

  task automatic issue_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                             input bit read_lost);
    logic [W-1:0] e;
    logic [31:0]  nw;
    bit mis;
    bit rd;
    int n;
    n = 0;
    while (!Req_Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!Req_Ready) fail_now("req_ready_wait");
    mis = model_misaligned(sz, a);
    rd  = !mis && !(FAST && sz[1] == 1'b0);
    if (mis || read_lost) begin
      e = {K_ERR, rd, 64'd0};
    end else begin
      nw = model_merge(sz, a, d, ref_mem[a[9:2]]);
      ref_mem[a[9:2]] = nw;
      e = {K_DONE, rd, a[31:2], 2'b00, nw};
    end
    exp_q.push_back(e);
    issue_base  = resp_cnt;
    Req_Valid   = 1'b1;
    Memory_Byte = sz;
    Address     = a;
    Data_In     = d;
    t_issue     = $time;
    @(negedge clk);
    Req_Valid   = 1'b0;
    Memory_Byte = 2'($urandom_range(0, 3));
    Address     = $urandom;
    Data_In     = $urandom;
  endtask

  task automatic wait_resp(output int lat);
    int n;
    n = 0;
    while (resp_cnt == issue_base && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (resp_cnt == issue_base) begin
      fail_now("resp_wait");
      exp_q.delete();
      lat = -1;
    end else begin
      lat = int'((resp_time - t_issue) / 10);
    end
  endtask

  // Memory responder: read data after rd_delay WAIT cycles, write ready after wr_delay.
  initial begin
    bit rd_active;
    int rd_cnt;
    int wr_cnt;
    logic [7:0] rd_idx;
    rd_active = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    rd_idx = '0;
    Mem_Read_Valid  = 1'b0;
    Mem_Read_Data   = '0;
    Mem_Write_Ready = 1'b0;
    forever begin
      @(negedge clk);
      Mem_Read_Valid  = 1'b0;
      Mem_Write_Ready = 1'b0;
      Mem_Read_Data   = $urandom;
      if (!rst_n) begin
        rd_active = 1'b0;
        wr_cnt = 0;
        continue;
      end
      if (rd_active) begin
        if (rd_cnt == 0) begin
          Mem_Read_Valid = 1'b1;
          Mem_Read_Data  = ram[rd_idx];
          rd_active = 1'b0;
        end else begin
          rd_cnt--;
        end
      end
      if (Mem_Read_En && !no_read_resp) begin
        rd_active = 1'b1;
        rd_cnt = rd_delay;
        rd_idx = Mem_Addr[9:2];
      end
      if (Mem_Write_En) begin
        if (wr_cnt >= wr_delay) begin
          Mem_Write_Ready = 1'b1;
          ram[Mem_Addr[9:2]] = Mem_Write_Data;
          wr_cnt = 0;
        end else begin
          wr_cnt++;
        end
      end else begin
        wr_cnt = 0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [W-1:0] e;
    int rd_seen;
    int wr_seen;
    rd_seen = 0;
    wr_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_seen = 0;
        wr_seen = 0;
        continue;
      end
      if (Mem_Read_En) rd_seen++;
      if (Mem_Write_En) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          fail_now("write_unexpected");
        end else begin
          e = exp_q[0];
          check("write_addr", 64'(Mem_Addr), 64'(e[63:32]));
          check("write_data", 64'(Mem_Write_Data), 64'(e[31:0]));
        end
      end
      if (Done || Error) begin
        check("done_error_exclusive", 64'(Done & Error), 64'd0);
        if (exp_q.size() == 0) begin
          fail_now("resp_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("resp_kind", 64'({Done, Error}), 64'(e[66:65]));
          check("resp_read_strobes", 64'(rd_seen), 64'(e[64]));
          if (Error) check("err_no_write", 64'(wr_seen), 64'd0);
          else       check("done_had_write", 64'(wr_seen != 0), 64'd1);
        end
        last_wr_cycles = wr_seen;
        resp_time = $time;
        resp_cnt++;
        rd_seen = 0;
        wr_seen = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [31:0] old;
    logic [1:0] sz;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs",
          64'({Req_Ready, Mem_Read_En, Mem_Write_En, Done, Error}), 64'd0);
    check("reset_mem_addr", 64'(Mem_Addr), 64'd0);
    check("reset_wdata", 64'(Mem_Write_Data), 64'd0);
    rst_n = 1'b1;
    #1 check("ready_low_after_release", 64'(Req_Ready), 64'd0);
    @(negedge clk);
    check("ready_high_one_cycle_later", 64'(Req_Ready), 64'd1);

    // sb lane 3
    rd_delay = 0; wr_delay = 0;
    preload(32'h0000_0100, 32'h1122_3344);
    issue_store(2'b11, 32'h0000_0103, 32'h0000_00AB, 1'b0);
    wait_resp(lat);
    check("sb_latency", 64'(lat), 64'd4);
    check("sb_ram", 64'(ram[8'h40]), 64'h0000_0000_AB22_3344);

    // sh upper half
    preload(32'h0000_0200, 32'h1122_3344);
    issue_store(2'b10, 32'h0000_0202, 32'h0000_BEEF, 1'b0);
    wait_resp(lat);
    check("sh_latency", 64'(lat), 64'd4);
    check("sh_ram", 64'(ram[8'h80]), 64'h0000_0000_BEEF_3344);

    // misaligned half and word
    issue_store(2'b10, 32'h0000_0201, 32'h0000_1234, 1'b0);
    wait_resp(lat);
    check("sh_misaligned_latency", 64'(lat), 64'd1);
    issue_store(2'b00, 32'h0000_0302, 32'h5555_AAAA, 1'b0);
    wait_resp(lat);
    check("sw_misaligned_latency", 64'(lat), 64'd1);

    // sw with write ready delayed 3 cycles
    wr_delay = 3;
    preload(32'h0000_0300, 32'h0BAD_F00D);
    issue_store(2'b00, 32'h0000_0300, 32'hDEAD_BEEF, 1'b0);
    wait_resp(lat);
    check("sw_write_en_cycles", 64'(last_wr_cycles), 64'd4);
    check("sw_latency", 64'(lat), FAST ? 64'd5 : 64'd7);
    check("sw_ram", 64'(ram[8'hC0]), 64'h0000_0000_DEAD_BEEF);
    wr_delay = 0;

    // read never returns
    no_read_resp = 1'b1;
    preload(32'h0000_0010, 32'hCAFE_0001);
    issue_store(2'b11, 32'h0000_0011, 32'h0000_0077, 1'b1);
    wait_resp(lat);
    check("timeout_latency", 64'(lat), 64'd18);
    check("timeout_ram_untouched", 64'(ram[8'h04]), 64'h0000_0000_CAFE_0001);
    no_read_resp = 1'b0;

    // reset while the write is pending
    preload(32'h0000_0404, 32'h5566_7788);
    old = 32'h5566_7788;
    wr_delay = 60;
    issue_store(2'b11, 32'h0000_0405, 32'h0000_0099, 1'b0);
    n = 0;
    while (!Mem_Write_En && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_write", 64'(Mem_Write_En), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_write_en_drops", 64'({Mem_Write_En, Req_Ready, Done, Error}), 64'd0);
    exp_q.delete();
    ref_mem[8'h01] = old;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_ready_low_at_release", 64'(Req_Ready), 64'd0);
    @(negedge clk);
    check("rst_ready_after_release", 64'(Req_Ready), 64'd1);
    check("rst_no_write", 64'(ram[8'h01]), 64'(old));
    wr_delay = 0;

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b10) a[0] = 1'b0;
        else if (sz[1] == 1'b0) a[1:0] = 2'b00;
      end
      rd_delay = $urandom_range(0, 3);
      wr_delay = $urandom_range(0, 3);
      issue_store(sz, a, $urandom, 1'b0);
      wait_resp(lat);
    end
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== ref_mem[i]) check("final_mem_image", 64'(ram[i]), 64'(ref_mem[i]));
    end
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
